// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two requesters.
// A round-robin grant picks a requester in IDLE. Its operands are registered
// onto the ALU, sampled after ALU_LAT cycles, and returned as a response.
// Optional feature macro: ALU_ARB_PERF_CNT_EN adds saturating per-requester
// grant counters (grant_cnt0/grant_cnt1) with a synchronous clear (cnt_clr).
module alu_share_arbiter #(
  parameter int W       = 16,
  parameter int ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         r0_valid,
  input  logic         r1_valid,
  output logic         r0_ready,
  output logic         r1_ready,
  input  logic [4:0]   r0_op,
  input  logic [4:0]   r1_op,
  input  logic [W-1:0] r0_a,
  input  logic [W-1:0] r1_a,
  input  logic [W-1:0] r0_b,
  input  logic [W-1:0] r1_b,
  output logic         r0_rsp_valid,
  output logic         r1_rsp_valid,
  input  logic         r0_rsp_ready,
  input  logic         r1_rsp_ready,
  output logic [W-1:0] r0_result,
  output logic [W-1:0] r1_result,
  output logic [3:0]   r0_flags,
  output logic [3:0]   r1_flags,
  output logic [4:0]   alu_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_result,
  input  logic [3:0]   alu_flags
`ifdef ALU_ARB_PERF_CNT_EN
  ,
  input  logic         cnt_clr,
  output logic [15:0]  grant_cnt0,
  output logic [15:0]  grant_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  // Last EXEC counter value; the ALU output is sampled in that cycle.
  localparam logic [3:0] LAST_CNT = 4'(ALU_LAT - 1);

  state_t       state;
  state_t       state_nxt;
  logic         last_grant;
  logic         owner;
  logic [3:0]   exec_cnt;
  logic [W-1:0] result_q;
  logic [3:0]   flags_q;

  logic         grant_valid;
  logic         grant;
  logic         accept;
  logic         own_rsp_ready;
  logic         rsp_done;

  // Round-robin arbitration: on a tie, the requester not served last wins.
  always_comb begin
    grant_valid = 1'b0;
    grant       = 1'b0;
    if (r0_valid && r1_valid) begin
      grant_valid = 1'b1;
      grant       = ~last_grant;
    end else if (r0_valid) begin
      grant_valid = 1'b1;
      grant       = 1'b0;
    end else if (r1_valid) begin
      grant_valid = 1'b1;
      grant       = 1'b1;
    end
  end

  assign r0_ready      = (state == IDLE) && grant_valid && (grant == 1'b0);
  assign r1_ready      = (state == IDLE) && grant_valid && (grant == 1'b1);
  assign accept        = (state == IDLE) && grant_valid;
  assign own_rsp_ready = owner ? r1_rsp_ready : r0_rsp_ready;
  assign rsp_done      = (state == RESP) && own_rsp_ready;

  assign r0_rsp_valid  = (state == RESP) && (owner == 1'b0);
  assign r1_rsp_valid  = (state == RESP) && (owner == 1'b1);
  assign r0_result     = result_q;
  assign r1_result     = result_q;
  assign r0_flags      = flags_q;
  assign r1_flags      = flags_q;

  // Next-state logic: accept, wait out the ALU settle time, then hold the response.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    if (exec_cnt == LAST_CNT) state_nxt = RESP;
      RESP:    if (own_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Transaction datapath: latch operands on accept, count EXEC cycles, capture the ALU output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      exec_cnt   <= '0;
      result_q   <= '0;
      flags_q    <= '0;
    end else begin
      if (accept) begin
        alu_op   <= grant ? r1_op : r0_op;
        alu_a    <= grant ? r1_a  : r0_a;
        alu_b    <= grant ? r1_b  : r0_b;
        owner    <= grant;
        exec_cnt <= '0;
      end else if (state == EXEC) begin
        exec_cnt <= exec_cnt + 4'd1;
        if (exec_cnt == LAST_CNT) begin
          result_q <= alu_result;
          flags_q  <= alu_flags;
        end
      end
      if (rsp_done) last_grant <= owner;
    end
  end

`ifdef ALU_ARB_PERF_CNT_EN
  // Saturating accept counters per requester; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (cnt_clr) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (accept) begin
      if (!grant && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (grant && grant_cnt1 != 16'hFFFF)  grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed self-checking bench for alu_share_arbiter.
// Two instances: dut (ALU_LAT=1) and dut3 (ALU_LAT=3), each with a small ALU model.
// Optional feature macro: ALU_ARB_PERF_CNT_EN enables the grant counter checks.
module tb_alu_share_arbiter;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic         r0_valid = 1'b0, r1_valid = 1'b0;
  logic         r0_ready, r1_ready;
  logic [4:0]   r0_op = '0, r1_op = '0;
  logic [W-1:0] r0_a = '0, r1_a = '0, r0_b = '0, r1_b = '0;
  logic         r0_rsp_valid, r1_rsp_valid;
  logic         r0_rsp_ready = 1'b0, r1_rsp_ready = 1'b0;
  logic [W-1:0] r0_result, r1_result;
  logic [3:0]   r0_flags, r1_flags;
  logic [4:0]   alu_op;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [3:0]   alu_flags;

  logic         s3_valid = 1'b0, s3_ready;
  logic [4:0]   s3_op = '0;
  logic [W-1:0] s3_a = '0, s3_b = '0;
  logic         s3_rsp_valid, s3_rsp_ready = 1'b0;
  logic [W-1:0] s3_result;
  logic [3:0]   s3_flags;
  logic         s3_r1_valid = 1'b0, s3_r1_ready;
  logic [4:0]   s3_r1_op = '0;
  logic [W-1:0] s3_r1_a = '0, s3_r1_b = '0;
  logic         s3_r1_rsp_valid, s3_r1_rsp_ready = 1'b0;
  logic [W-1:0] s3_r1_result;
  logic [3:0]   s3_r1_flags;
  logic [4:0]   s3_alu_op;
  logic [W-1:0] s3_alu_a, s3_alu_b, s3_alu_result;
  logic [3:0]   s3_alu_flags;

`ifdef ALU_ARB_PERF_CNT_EN
  logic         cnt_clr = 1'b0;
  logic [15:0]  grant_cnt0, grant_cnt1, s3_cnt0, s3_cnt1;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          who;
    logic [4:0]  op;
    logic [15:0] exp_res;
    logic [3:0]  exp_flags;
  } vec_t;

  vec_t tbl [6];

  // Free-running clock.
  always #5 clk = ~clk;

  // Reference ALU: add, sub, arithmetic shift right; flags = {neg, zero, op[1], op[0]}.
  function automatic logic [19:0] alu_model(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    case (op)
      5'd0:    r = a + b;
      5'd1:    r = a - b;
      5'd5:    r = $signed(a) >>> b[3:0];
      default: r = a ^ b;
    endcase
    return {r[15], (r == 16'd0), op[1], op[0], r};
  endfunction

  assign {alu_flags, alu_result}       = alu_model(alu_op, alu_a, alu_b);
  assign {s3_alu_flags, s3_alu_result} = alu_model(s3_alu_op, s3_alu_a, s3_alu_b);

  alu_share_arbiter #(.W(W), .ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r1_valid(r1_valid),
    .r0_ready(r0_ready), .r1_ready(r1_ready),
    .r0_op(r0_op), .r1_op(r1_op),
    .r0_a(r0_a), .r1_a(r1_a), .r0_b(r0_b), .r1_b(r1_b),
    .r0_rsp_valid(r0_rsp_valid), .r1_rsp_valid(r1_rsp_valid),
    .r0_rsp_ready(r0_rsp_ready), .r1_rsp_ready(r1_rsp_ready),
    .r0_result(r0_result), .r1_result(r1_result),
    .r0_flags(r0_flags), .r1_flags(r1_flags),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_flags(alu_flags)
`ifdef ALU_ARB_PERF_CNT_EN
    , .cnt_clr(cnt_clr), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  alu_share_arbiter #(.W(W), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(s3_valid), .r1_valid(s3_r1_valid),
    .r0_ready(s3_ready), .r1_ready(s3_r1_ready),
    .r0_op(s3_op), .r1_op(s3_r1_op),
    .r0_a(s3_a), .r1_a(s3_r1_a), .r0_b(s3_b), .r1_b(s3_r1_b),
    .r0_rsp_valid(s3_rsp_valid), .r1_rsp_valid(s3_r1_rsp_valid),
    .r0_rsp_ready(s3_rsp_ready), .r1_rsp_ready(s3_r1_rsp_ready),
    .r0_result(s3_result), .r1_result(s3_r1_result),
    .r0_flags(s3_flags), .r1_flags(s3_r1_flags),
    .alu_op(s3_alu_op), .alu_a(s3_alu_a), .alu_b(s3_alu_b),
    .alu_result(s3_alu_result), .alu_flags(s3_alu_flags)
`ifdef ALU_ARB_PERF_CNT_EN
    , .cnt_clr(cnt_clr), .grant_cnt0(s3_cnt0), .grant_cnt1(s3_cnt1)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s timed out waiting for DUT", name);
  endtask

  task automatic applyStimulus(input bit who, input bit valid, input logic [4:0] op,
                               input logic [15:0] a, input logic [15:0] b);
    if (who) begin
      r1_valid = valid; r1_op = op; r1_a = a; r1_b = b;
    end else begin
      r0_valid = valid; r0_op = op; r0_a = a; r0_b = b;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    r0_valid = 1'b0; r1_valid = 1'b0; s3_valid = 1'b0;
    r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b0; s3_rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_ready(input bit who, input string name);
    int n = 0;
    #1;
    while (!(who ? r1_ready : r0_ready) && n < 20) begin
      next_cycle(); #1; n++;
    end
    if (n >= 20) timeout_fail(name);
  endtask

  task automatic wait_rsp(input bit who, input string name);
    int n = 0;
    #1;
    while (!(who ? r1_rsp_valid : r0_rsp_valid) && n < 20) begin
      next_cycle(); #1; n++;
    end
    if (n >= 20) timeout_fail(name);
  endtask

  task automatic do_txn(input bit who, input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
    applyStimulus(who, 1'b1, op, a, b);
    wait_ready(who, "txn_ready");
    next_cycle();
    applyStimulus(who, 1'b0, op, a, b);
    wait_rsp(who, "txn_rsp");
    next_cycle();
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed test sequence.
  initial begin
    tbl[0] = '{1'b0, 5'd0, 16'hFFF0, 4'b1000};
    tbl[1] = '{1'b1, 5'd0, 16'h001B, 4'b0000};
    tbl[2] = '{1'b0, 5'd1, 16'hFFF6, 4'b1001};
    tbl[3] = '{1'b1, 5'd1, 16'h0005, 4'b0001};
    tbl[4] = '{1'b0, 5'd5, 16'hFFFF, 4'b1001};
    tbl[5] = '{1'b1, 5'd5, 16'h0000, 4'b0101};

    do_reset();
    #1;
    checkOutput("rst_r0_ready", r0_ready, 0);
    checkOutput("rst_r1_ready", r1_ready, 0);
    checkOutput("rst_rsp_valid", {r0_rsp_valid, r1_rsp_valid}, 0);
    checkOutput("rst_alu_op", alu_op, 0);
    checkOutput("rst_alu_a", alu_a, 0);
    checkOutput("rst_alu_b", alu_b, 0);
    checkOutput("rst_result", r0_result, 0);
    checkOutput("rst_flags", r0_flags, 0);

    // Single r0 request, ALU_LAT=1.
    next_cycle();
    applyStimulus(0, 1, 5'b00101, 16'd32, 16'd5);
    #1;
    checkOutput("t1_r0_ready", r0_ready, 1);
    checkOutput("t1_r1_ready", r1_ready, 0);
    next_cycle();
    applyStimulus(0, 0, 5'b00101, 16'd32, 16'd5);
    #1;
    checkOutput("t1_exec_rsp_valid", r0_rsp_valid, 0);
    checkOutput("t1_exec_r0_ready", r0_ready, 0);
    checkOutput("t1_alu_op", alu_op, 5'b00101);
    checkOutput("t1_alu_a", alu_a, 32);
    checkOutput("t1_alu_b", alu_b, 5);
    next_cycle();
    r0_rsp_ready = 1'b1;
    #1;
    checkOutput("t1_rsp_valid", r0_rsp_valid, 1);
    checkOutput("t1_result", r0_result, 16'h0001);
    checkOutput("t1_flags", r0_flags, 4'b0001);
    checkOutput("t1_r1_rsp_valid", r1_rsp_valid, 0);
    next_cycle();
    r0_rsp_ready = 1'b0;
    #1;
    checkOutput("t1_rsp_done", r0_rsp_valid, 0);

    // Reset asserted during EXEC of an r1 request.
    next_cycle();
    applyStimulus(1, 1, 5'd0, 16'd5, 16'd6);
    #1;
    checkOutput("rs_r1_ready", r1_ready, 1);
    next_cycle();
    applyStimulus(1, 0, 5'd0, 16'd5, 16'd6);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rs_alu_a", alu_a, 0);
    checkOutput("rs_alu_b", alu_b, 0);
    checkOutput("rs_alu_op", alu_op, 0);
    checkOutput("rs_result", r0_result, 0);
    checkOutput("rs_flags", r0_flags, 0);
    checkOutput("rs_ready", {r0_ready, r1_ready}, 0);
    checkOutput("rs_rsp_valid", {r0_rsp_valid, r1_rsp_valid}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput($sformatf("rs_no_rsp%0d", k), {r0_rsp_valid, r1_rsp_valid}, 0);
      next_cycle();
    end
    applyStimulus(0, 1, 5'd0, 16'd1, 16'd1);
    applyStimulus(1, 1, 5'd0, 16'd2, 16'd2);
    #1;
    checkOutput("rs_first_r0_ready", r0_ready, 1);
    checkOutput("rs_first_r1_ready", r1_ready, 0);

    // Round-robin with both requesters valid continuously.
    do_reset();
    r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
    applyStimulus(0, 1, tbl[0].op, 16'hFFF3, 16'hFFFD);
    applyStimulus(1, 1, tbl[1].op, 16'd16, 16'd11);
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].who) r1_op = tbl[i].op;
      else            r0_op = tbl[i].op;
      #1;
      checkOutput($sformatf("alt%0d_r0_ready", i), r0_ready, !tbl[i].who);
      checkOutput($sformatf("alt%0d_r1_ready", i), r1_ready, tbl[i].who);
      next_cycle();
      wait_rsp(tbl[i].who, $sformatf("alt%0d_rsp", i));
      checkOutput($sformatf("alt%0d_result", i), tbl[i].who ? r1_result : r0_result, tbl[i].exp_res);
      checkOutput($sformatf("alt%0d_flags", i), tbl[i].who ? r1_flags : r0_flags, tbl[i].exp_flags);
      checkOutput($sformatf("alt%0d_other_rsp", i), tbl[i].who ? r0_rsp_valid : r1_rsp_valid, 0);
      next_cycle();
    end

    // Backpressure on r1 response; r0 waits and its rsp_ready is ignored.
    do_reset();
    applyStimulus(1, 1, 5'd0, 16'd16, 16'd11);
    #1;
    checkOutput("bp_r1_ready", r1_ready, 1);
    next_cycle();
    applyStimulus(1, 0, 5'd0, 16'd16, 16'd11);
    applyStimulus(0, 1, 5'd1, 16'd7, 16'd2);
    r0_rsp_ready = 1'b1;
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput($sformatf("bp%0d_rsp_valid", k), r1_rsp_valid, 1);
      checkOutput($sformatf("bp%0d_result", k), r1_result, 16'h001B);
      checkOutput($sformatf("bp%0d_alu", k), {alu_op, alu_a, alu_b}, {5'd0, 16'd16, 16'd11});
      checkOutput($sformatf("bp%0d_r0_ready", k), r0_ready, 0);
      next_cycle();
    end
    r1_rsp_ready = 1'b1;
    #1;
    checkOutput("bp_release_rsp_valid", r1_rsp_valid, 1);
    next_cycle();
    #1;
    checkOutput("bp_idle_rsp_valid", r1_rsp_valid, 0);
    checkOutput("bp_idle_r0_ready", r0_ready, 1);

    // ALU_LAT=3 instance.
    do_reset();
    s3_valid = 1'b1; s3_op = 5'd1; s3_a = 16'd16; s3_b = 16'd10;
    #1;
    checkOutput("l3_ready", s3_ready, 1);
    checkOutput("l3_r1_ready", s3_r1_ready, 0);
    next_cycle();
    s3_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      checkOutput($sformatf("l3_wait%0d", k), s3_rsp_valid, 0);
      next_cycle();
    end
    s3_rsp_ready = 1'b1;
    #1;
    checkOutput("l3_rsp_valid", s3_rsp_valid, 1);
    checkOutput("l3_r1_rsp_valid", s3_r1_rsp_valid, 0);
    checkOutput("l3_result", s3_result, 16'd6);
    checkOutput("l3_flags", s3_flags, 4'b0001);
    checkOutput("l3_alu_ab", {s3_alu_a, s3_alu_b}, {16'd16, 16'd10});
    next_cycle();
    #1;
    checkOutput("l3_done", s3_rsp_valid, 0);

`ifdef ALU_ARB_PERF_CNT_EN
    // Grant counters.
    do_reset();
    for (int k = 0; k < 4; k++) do_txn(0, 5'd0, 16'(k), 16'd1);
    for (int k = 0; k < 2; k++) do_txn(1, 5'd1, 16'(k), 16'd1);
    #1;
    checkOutput("pc_cnt0", grant_cnt0, 4);
    checkOutput("pc_cnt1", grant_cnt1, 2);
    cnt_clr = 1'b1;
    next_cycle();
    cnt_clr = 1'b0;
    #1;
    checkOutput("pc_clr0", grant_cnt0, 0);
    checkOutput("pc_clr1", grant_cnt1, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
